// File: rtl/stream_arb_mux_arb.sv
// Request arbiter: round-robin or fixed priority, optionally holding
// a grant until the granted requester acknowledges.
module stream_arb_mux_arb #(
   parameter int PORTS                 = 4,
   parameter int ARB_TYPE_ROUND_ROBIN  = 0,
   parameter int ARB_BLOCK             = 0,
   parameter int ARB_BLOCK_ACK         = 1,
   parameter int ARB_LSB_HIGH_PRIORITY = 0,
   localparam int CL_PORTS = (PORTS > 1) ? $clog2(PORTS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PORTS-1:0]    request_i,
   input  logic [PORTS-1:0]    ack_i,
   output logic [PORTS-1:0]    grant_o,
   output logic                grant_valid_o,
   output logic [CL_PORTS-1:0] grant_enc_o
);

   logic [PORTS-1:0]    grant_q, grant_d;
   logic [PORTS-1:0]    mask_q, mask_d;
   logic                gv_q, gv_d;
   logic [CL_PORTS-1:0] enc_q, enc_d;
   logic [PORTS-1:0]    mreq;
   logic [CL_PORTS-1:0] pick;
   logic                hold;

   function automatic logic [CL_PORTS-1:0] prio_enc(
      input logic [PORTS-1:0] v
   );
      logic [CL_PORTS-1:0] idx;
      idx = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (ARB_LSB_HIGH_PRIORITY != 0) begin
            if (v[PORTS-1-i]) idx = CL_PORTS'(PORTS-1-i);
         end else begin
            if (v[i]) idx = CL_PORTS'(i);
         end
      end
      return idx;
   endfunction

   function automatic logic [PORTS-1:0] onehot(
      input logic [CL_PORTS-1:0] idx
   );
      logic [PORTS-1:0] v;
      v = '0;
      for (int i = 0; i < PORTS; i++) v[i] = (i == int'(idx));
      return v;
   endfunction

   // Ports that outrank the last winner on the next round
   function automatic logic [PORTS-1:0] mask_after(
      input logic [CL_PORTS-1:0] idx
   );
      logic [PORTS-1:0] m;
      m = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (ARB_LSB_HIGH_PRIORITY != 0) m[i] = (i > int'(idx));
         else                            m[i] = (i < int'(idx));
      end
      return m;
   endfunction

   always_comb begin
      grant_d = grant_q;
      mask_d  = mask_q;
      gv_d    = gv_q;
      enc_d   = enc_q;
      mreq    = request_i & mask_q;
      hold    = 1'b0;
      if (ARB_BLOCK != 0 && ARB_BLOCK_ACK == 0) begin
         hold = |(grant_q & request_i);
      end else if (ARB_BLOCK != 0) begin
         hold = gv_q && !(|(grant_q & ack_i));
      end
      if (ARB_TYPE_ROUND_ROBIN != 0 && |mreq) pick = prio_enc(mreq);
      else                                    pick = prio_enc(request_i);
      if (!hold) begin
         if (|request_i) begin
            gv_d    = 1'b1;
            grant_d = onehot(pick);
            enc_d   = pick;
            if (ARB_TYPE_ROUND_ROBIN != 0) mask_d = mask_after(pick);
         end else begin
            gv_d    = 1'b0;
            grant_d = '0;
            enc_d   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q <= '0;
         mask_q  <= '0;
         gv_q    <= 1'b0;
         enc_q   <= '0;
      end else begin
         grant_q <= grant_d;
         mask_q  <= mask_d;
         gv_q    <= gv_d;
         enc_q   <= enc_d;
      end
   end

   assign grant_o       = grant_q;
   assign grant_valid_o = gv_q;
   assign grant_enc_o   = enc_q;

endmodule

// File: rtl/stream_arb_mux.sv
// Packet-granular N:1 stream merge: arbitrated input select feeding a
// two-entry skid buffer so the input ready is fully registered.
module stream_arb_mux #(
   parameter int PORTS                 = 4,
   parameter int DATA_WIDTH            = 8,
   parameter int ARB_TYPE_ROUND_ROBIN  = 1,
   parameter int ARB_LSB_HIGH_PRIORITY = 1,
   localparam int CL_PORTS = (PORTS > 1) ? $clog2(PORTS) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [PORTS*DATA_WIDTH-1:0] s_data,
   input  logic [PORTS-1:0]            s_valid,
   output logic [PORTS-1:0]            s_ready,
   input  logic [PORTS-1:0]            s_last,
   output logic [DATA_WIDTH-1:0]       m_data,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic                        m_last,
   output logic [CL_PORTS-1:0]         m_id
);

   logic [PORTS-1:0]      grant;
   logic                  grant_valid;
   logic [CL_PORTS-1:0]   grant_enc;
   logic [PORTS-1:0]      ack;

   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  in_valid;

   logic                  ready_int_q;
   logic                  ready_early;
   logic [DATA_WIDTH-1:0] m_data_q, tmp_data_q;
   logic                  m_last_q, tmp_last_q;
   logic [CL_PORTS-1:0]   m_id_q, tmp_id_q;
   logic                  m_valid_q, m_valid_d;
   logic                  tmp_valid_q, tmp_valid_d;
   logic                  to_out, to_tmp, tmp_to_out;

   stream_arb_mux_arb #(
      .PORTS                 (PORTS),
      .ARB_TYPE_ROUND_ROBIN  (ARB_TYPE_ROUND_ROBIN),
      .ARB_BLOCK             (1),
      .ARB_BLOCK_ACK         (1),
      .ARB_LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
   ) u_arb (
      .clk           (clk),
      .rst           (rst),
      .request_i     (s_valid),
      .ack_i         (ack),
      .grant_o       (grant),
      .grant_valid_o (grant_valid),
      .grant_enc_o   (grant_enc)
   );

   assign s_ready = (ready_int_q && grant_valid) ? grant : '0;
   assign ack     = grant & s_valid & s_ready & s_last;

   always_comb begin
      in_data = '0;
      in_last = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
         if (grant[i]) begin
            in_data = s_data[i*DATA_WIDTH +: DATA_WIDTH];
            in_last = s_last[i];
         end
      end
   end

   assign in_valid = (|(grant & s_valid)) && ready_int_q && grant_valid;

   // Accept next cycle unless both entries could end up occupied
   assign ready_early = m_ready ||
      (!tmp_valid_q && (!m_valid_q || !in_valid));

   always_comb begin
      m_valid_d   = m_valid_q;
      tmp_valid_d = tmp_valid_q;
      to_out      = 1'b0;
      to_tmp      = 1'b0;
      tmp_to_out  = 1'b0;
      if (ready_int_q) begin
         if (m_ready || !m_valid_q) begin
            m_valid_d = in_valid;
            to_out    = 1'b1;
         end else begin
            tmp_valid_d = in_valid;
            to_tmp      = 1'b1;
         end
      end else if (m_ready) begin
         m_valid_d   = tmp_valid_q;
         tmp_valid_d = 1'b0;
         tmp_to_out  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid_q   <= 1'b0;
         tmp_valid_q <= 1'b0;
         ready_int_q <= 1'b0;
         m_last_q    <= 1'b0;
         m_id_q      <= '0;
         tmp_last_q  <= 1'b0;
         tmp_id_q    <= '0;
      end else begin
         m_valid_q   <= m_valid_d;
         tmp_valid_q <= tmp_valid_d;
         ready_int_q <= ready_early;
         if (to_out) begin
            m_last_q <= in_last;
            m_id_q   <= grant_enc;
         end else if (tmp_to_out) begin
            m_last_q <= tmp_last_q;
            m_id_q   <= tmp_id_q;
         end
         if (to_tmp) begin
            tmp_last_q <= in_last;
            tmp_id_q   <= grant_enc;
         end
      end
   end

   // Payload is qualified by m_valid, so it carries no reset
   always_ff @(posedge clk) begin
      if (to_out)          m_data_q <= in_data;
      else if (tmp_to_out) m_data_q <= tmp_data_q;
      if (to_tmp)          tmp_data_q <= in_data;
   end

   assign m_data  = m_data_q;
   assign m_valid = m_valid_q;
   assign m_last  = m_last_q;
   assign m_id    = m_id_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed scoreboard bench for stream_arb_mux: a round-robin instance
// and a fixed-priority instance.
module tb_stream_arb_mux;

   localparam int P = 4;
   localparam int W = 8;

   typedef struct packed {
      logic [1:0] id;
      logic       last;
      logic [7:0] data;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [P*W-1:0] s_data = '0;
   logic [P-1:0] s_valid = '0;
   logic [P-1:0] s_last = '0;
   logic [P-1:0] s_ready;
   logic [W-1:0] m_data;
   logic         m_valid;
   logic         m_ready = 1'b0;
   logic         m_last;
   logic [1:0]   m_id;

   logic [P*W-1:0] fp_s_data = 32'hA3A2A1A0;
   logic [P-1:0] fp_s_valid = '0;
   logic [P-1:0] fp_s_last = '1;
   logic [P-1:0] fp_s_ready;
   logic [W-1:0] fp_m_data;
   logic         fp_m_valid;
   logic         fp_m_ready = 1'b1;
   logic         fp_m_last;
   logic [1:0]   fp_m_id;

   always #5 clk = ~clk;

   stream_arb_mux #(
      .PORTS(P), .DATA_WIDTH(W),
      .ARB_TYPE_ROUND_ROBIN(1), .ARB_LSB_HIGH_PRIORITY(1)
   ) dut (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .s_last(s_last),
      .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_last(m_last), .m_id(m_id)
   );

   stream_arb_mux #(
      .PORTS(P), .DATA_WIDTH(W),
      .ARB_TYPE_ROUND_ROBIN(0), .ARB_LSB_HIGH_PRIORITY(1)
   ) dut_fp (
      .clk(clk), .rst(rst),
      .s_data(fp_s_data), .s_valid(fp_s_valid),
      .s_ready(fp_s_ready), .s_last(fp_s_last),
      .m_data(fp_m_data), .m_valid(fp_m_valid),
      .m_ready(fp_m_ready), .m_last(fp_m_last), .m_id(fp_m_id)
   );

   beat_t port_q[P][$];
   beat_t sb[$];
   int    id_log[$];
   bit    mr_q[$];
   int    vectors = 0;
   int    miscompares = 0;
   int    cyc = 0;
   int    out_beats = 0;
   int    out_first = -1;
   int    out_last = -1;
   int    sv_rise = -1;
   int    mv_rise = -1;
   int    fp_beats = 0;
   bit    rst_req = 1'b0;
   bit    fp_en = 1'b0;
   bit    sv_prev = 1'b0;
   bit    mv_prev = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_pkt(input int p, input int n,
                           input logic [7:0] base);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.id   = 2'(p);
         b.last = (k == n - 1);
         b.data = base + 8'(k);
         port_q[p].push_back(b);
      end
   endtask

   task automatic begin_phase();
      out_beats = 0;
      out_first = -1;
      out_last  = -1;
      sv_rise   = -1;
      mv_rise   = -1;
      id_log.delete();
   endtask

   task automatic do_reset();
      rst_req = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic wait_out(input int n);
      int t;
      t = 0;
      while (out_beats < n && t < 300) begin
         @(posedge clk);
         t++;
      end
      chk("wait_out", out_beats, n);
   endtask

   function automatic int log_at(input int i);
      return (i < id_log.size()) ? id_log[i] : -1;
   endfunction

   // Driver and monitor: all input changes and output sampling on negedge
   initial begin : drive
      beat_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_req || cyc < 3) begin
            rst        = 1'b1;
            s_valid    = '0;
            s_last     = '0;
            m_ready    = 1'b0;
            fp_s_valid = '0;
            for (int p = 0; p < P; p++) port_q[p].delete();
            sb.delete();
            rst_req = 1'b0;
            sv_prev = 1'b0;
            mv_prev = 1'b0;
         end else begin
            if (rst) begin
               rst = 1'b0;
               chk("rst_m_valid", m_valid, 0);
               chk("rst_s_ready", s_ready, 0);
               chk("rst_m_last", m_last, 0);
               chk("rst_m_id", m_id, 0);
               chk("rst_fp_m_valid", fp_m_valid, 0);
            end
            m_ready = (mr_q.size() > 0) ? mr_q.pop_front() : 1'b1;
            if (m_valid) begin
               chk("beat_expected", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                  e = sb[0];
                  chk("m_data", m_data, e.data);
                  chk("m_id", m_id, e.id);
                  chk("m_last", m_last, e.last);
                  if (m_ready) begin
                     void'(sb.pop_front());
                     id_log.push_back(int'(m_id));
                     if (out_first < 0) out_first = cyc;
                     out_last = cyc;
                     out_beats++;
                  end
               end
               if (!mv_prev && mv_rise < 0) mv_rise = cyc;
            end
            mv_prev = m_valid;
            for (int p = 0; p < P; p++) begin
               if (port_q[p].size() > 0) begin
                  s_valid[p]        = 1'b1;
                  s_last[p]         = port_q[p][0].last;
                  s_data[p*W +: W]  = port_q[p][0].data;
               end else begin
                  s_valid[p] = 1'b0;
                  s_last[p]  = 1'b0;
               end
            end
            chk("s_ready_onehot", $onehot0(s_ready), 1);
            for (int p = 0; p < P; p++) begin
               if (s_valid[p] && s_ready[p])
                  sb.push_back(port_q[p].pop_front());
            end
            if (|s_valid && !sv_prev && sv_rise < 0) sv_rise = cyc;
            sv_prev = |s_valid;
            fp_s_valid = fp_en ? 4'b1010 : 4'b0000;
            if (fp_m_valid) begin
               chk("fp_m_id", fp_m_id, 1);
               chk("fp_m_data", fp_m_data, 8'hA1);
               fp_beats++;
            end
         end
      end
   end

   initial begin : main
      int exp_rr[8];
      int exp_at[5];
      int t;
      exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
      exp_at = '{2, 2, 2, 2, 0};
      repeat (4) @(posedge clk);

      begin_phase();
      push_pkt(0, 3, 8'h11);
      wait_out(3);
      chk("smoke_latency", mv_rise - sv_rise, 2);
      chk("smoke_span", out_last - out_first, 2);

      do_reset();
      begin_phase();
      for (int p = 0; p < P; p++) push_pkt(p, 1, 8'(p * 16));
      for (int p = 0; p < P; p++) push_pkt(p, 1, 8'(p * 16 + 1));
      wait_out(8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("rr_id[%0d]", i), log_at(i), exp_rr[i]);
      chk("rr_span", out_last - out_first, 7);

      do_reset();
      begin_phase();
      push_pkt(2, 4, 8'h30);
      t = 0;
      while (port_q[2].size() > 2 && t < 100) begin
         @(posedge clk);
         t++;
      end
      chk("atom_wait", port_q[2].size() <= 2, 1);
      push_pkt(0, 1, 8'h50);
      wait_out(5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("atom_id[%0d]", i), log_at(i), exp_at[i]);
      chk("atom_span", out_last - out_first, 4);

      do_reset();
      begin_phase();
      for (int r = 0; r < 6; r++) begin
         mr_q.push_back(1'b1);
         mr_q.push_back(1'b0);
         mr_q.push_back(1'b0);
         mr_q.push_back(1'b1);
         mr_q.push_back(1'b1);
         mr_q.push_back(1'b0);
      end
      push_pkt(1, 5, 8'h60);
      wait_out(5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("bp_id[%0d]", i), log_at(i), 1);
      mr_q.delete();

      do_reset();
      begin_phase();
      push_pkt(3, 4, 8'h70);
      wait_out(2);
      do_reset();
      begin_phase();
      push_pkt(3, 1, 8'h7F);
      push_pkt(1, 1, 8'h90);
      wait_out(2);
      chk("rst_first_id", log_at(0), 1);
      chk("rst_second_id", log_at(1), 3);

      fp_en = 1'b1;
      repeat (20) @(posedge clk);
      fp_en = 1'b0;
      repeat (4) @(posedge clk);
      chk("fp_beats", fp_beats >= 15, 1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
